// File: rtl/gcd_arbiter.sv
// -----------------------------------------------------------------------------
// gcd_arbiter
// Round-robin arbiter that shares a single gcd_ci custom-instruction unit
// between NUM_REQ requesters. It grants one requester at a time, forwards that
// requester's operands, sequences the gcd start/done handshake and returns the
// result to the granted requester only. Single clock domain, every output
// registered.
//
// Parameters
//   NUM_REQ         number of requesters (2..8)
//   DATA_W          operand/result width, matches gcd_ci
//   TIMEOUT_CYCLES  watchdog limit in cycles (only with GCD_ARB_TIMEOUT_EN)
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   req_valid    in   per-requester request, held until its resp_valid
//   req_dataa    in   operand a, requester i in [i*DATA_W +: DATA_W]
//   req_datab    in   operand b, same packing
//   resp_valid   out  one-hot, one-cycle completion pulse to the granted requester
//   resp_result  out  gcd result, valid while resp_valid != 0
//   resp_err     out  timeout flag, qualified by resp_valid
//   busy         out  high in every state except IDLE
//   gcd_start    out  to gcd_ci start (held until gcd_done drops)
//   gcd_dataa    out  to gcd_ci dataa, holds until the next grant
//   gcd_datab    out  to gcd_ci datab, holds until the next grant
//   gcd_done     in   from gcd_ci done (high = idle/finished)
//   gcd_result   in   from gcd_ci result
//
// Configuration macro
//   GCD_ARB_TIMEOUT_EN : when defined, a watchdog counter aborts an operation
//   after TIMEOUT_CYCLES cycles in ISSUE/RUN and responds with resp_err=1 and
//   resp_result=0. When undefined, resp_err is always 0 and ISSUE/RUN wait
//   indefinitely.
// -----------------------------------------------------------------------------
module gcd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_dataa,
    input  logic [NUM_REQ*DATA_W-1:0] req_datab,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_result,
    output logic                      resp_err,
    output logic                      busy,
    output logic                      gcd_start,
    output logic [DATA_W-1:0]         gcd_dataa,
    output logic [DATA_W-1:0]         gcd_datab,
    input  logic                      gcd_done,
    input  logic [DATA_W-1:0]         gcd_result
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time guard on the supported parameter range.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("gcd_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    grant_q;
    logic [IDX_W-1:0]    grant_d;
    logic [NUM_REQ-1:0]  resp_valid_q;
    logic [DATA_W-1:0]   resp_result_q;
    logic                resp_err_q;
    logic                busy_q;
    logic                gcd_start_q;
    logic [DATA_W-1:0]   gcd_dataa_q;
    logic [DATA_W-1:0]   gcd_datab_q;
    logic                tmo_hit_s;

    // Next index after idx, wrapping at NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            wrap_inc = '0;
        end else begin
            wrap_inc = idx + IDX_W'(1);
        end
    endfunction

    // First set bit of vld searching upward from ptr with wrap. The scan runs
    // from the farthest candidate back to ptr so the closest match is written last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] cand;
        rr_pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand    = IDX_W'((int'(ptr) + k) % NUM_REQ);
            rr_pick = vld[cand] ? cand : rr_pick;
        end
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        to_onehot      = '0;
        to_onehot[idx] = 1'b1;
    endfunction

    // Round-robin candidate for the next grant.
    always_comb begin
        grant_d = rr_pick(req_valid, rr_ptr_q);
    end

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;

    // Watchdog: zero outside ISSUE/RUN, so it starts from zero on entry to ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_ISSUE || state_q == ST_RUN) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th cycle spent in ISSUE/RUN.
    assign tmo_hit_s = (state_q == ST_ISSUE || state_q == ST_RUN) &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Main FSM with all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_err_q    <= 1'b0;
            busy_q        <= 1'b0;
            gcd_start_q   <= 1'b0;
            gcd_dataa_q   <= '0;
            gcd_datab_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // gcd_done low means the unit is still draining an aborted op.
                    if ((|req_valid) && gcd_done) begin
                        grant_q     <= grant_d;
                        gcd_dataa_q <= req_dataa[int'(grant_d)*DATA_W +: DATA_W];
                        gcd_datab_q <= req_datab[int'(grant_d)*DATA_W +: DATA_W];
                        gcd_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (tmo_hit_s) begin
                        gcd_start_q   <= 1'b0;
                        resp_valid_q  <= to_onehot(grant_q);
                        resp_result_q <= '0;
                        resp_err_q    <= 1'b1;
                        state_q       <= ST_RESP;
                    end else if (!gcd_done) begin
                        // gcd_ci has accepted the start edge.
                        gcd_start_q   <= 1'b0;
                        state_q       <= ST_RUN;
                    end else begin
                        state_q       <= ST_ISSUE;
                    end
                end
                ST_RUN: begin
                    if (tmo_hit_s) begin
                        resp_valid_q  <= to_onehot(grant_q);
                        resp_result_q <= '0;
                        resp_err_q    <= 1'b1;
                        state_q       <= ST_RESP;
                    end else if (gcd_done) begin
                        resp_valid_q  <= to_onehot(grant_q);
                        resp_result_q <= gcd_result;
                        resp_err_q    <= 1'b0;
                        state_q       <= ST_RESP;
                    end else begin
                        state_q       <= ST_RUN;
                    end
                end
                ST_RESP: begin
                    resp_valid_q  <= '0;
                    resp_result_q <= '0;
                    resp_err_q    <= 1'b0;
                    rr_ptr_q      <= wrap_inc(grant_q);
                    busy_q        <= 1'b0;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    resp_valid_q  <= '0;
                    resp_err_q    <= 1'b0;
                    busy_q        <= 1'b0;
                    gcd_start_q   <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_err    = resp_err_q;
    assign busy        = busy_q;
    assign gcd_start   = gcd_start_q;
    assign gcd_dataa   = gcd_dataa_q;
    assign gcd_datab   = gcd_datab_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gcd_arbiter
// Bench for gcd_arbiter: a behavioural gcd_ci model answers the arbiter, and a
// reference model (Euclid's algorithm plus circular-order grant selection)
// provides the expected grant index and result for every response.
// -----------------------------------------------------------------------------
module tb_gcd_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int TMO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_dataa;
    logic [N*W-1:0]   req_datab;
    logic [N-1:0]     resp_valid;
    logic [W-1:0]     resp_result;
    logic             resp_err;
    logic             busy;
    logic             gcd_start;
    logic [W-1:0]     gcd_dataa;
    logic [W-1:0]     gcd_datab;
    logic             gcd_done;
    logic [W-1:0]     gcd_result;

    int n_cmp  = 0;
    int n_fail = 0;
    int ref_ptr = 0;
    bit stuck = 1'b0;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];

    always #5 clk = ~clk;

    gcd_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dataa(req_dataa), .req_datab(req_datab),
        .resp_valid(resp_valid), .resp_result(resp_result), .resp_err(resp_err),
        .busy(busy), .gcd_start(gcd_start), .gcd_dataa(gcd_dataa), .gcd_datab(gcd_datab),
        .gcd_done(gcd_done), .gcd_result(gcd_result)
    );

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    // First pending requester in circular order starting at ptr.
    function automatic int ref_next(input logic [N-1:0] vld, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (vld[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Behavioural gcd_ci: edge-detects start, drops done for a random latency.
    logic         m_start_prev;
    int           m_cnt;
    logic [W-1:0] m_a, m_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gcd_done <= 1'b1; gcd_result <= '0; m_start_prev <= 1'b0;
            m_cnt <= 0; m_a <= '0; m_b <= '0;
        end else begin
            m_start_prev <= gcd_start;
            if (gcd_start && !m_start_prev && gcd_done) begin
                gcd_done <= 1'b0; m_a <= gcd_dataa; m_b <= gcd_datab;
                m_cnt <= $urandom_range(1, 5);
            end else if (!gcd_done && !stuck) begin
                if (m_cnt == 0) begin
                    gcd_done <= 1'b1; gcd_result <= ref_gcd(m_a, m_b);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        opa[i] = a; opb[i] = b;
        req_dataa[i*W +: W] = a;
        req_datab[i*W +: W] = b;
    endtask

    task automatic rand_op(input int i);
        int g;
        g = $urandom_range(1, 60);
        set_op(i, W'(g * $urandom_range(0, 3000)), W'(g * $urandom_range(0, 3000)));
    endtask

    // Waits (bounded) for a response; lat = cycles from gcd_done rising to resp_valid.
    task automatic wait_resp(input int max_cyc, output int idx, output logic [W-1:0] res,
                             output logic err, output int lat, output bit to);
        int   rise_n;
        logic prev_done;
        idx = -1; res = '0; err = 1'b0; lat = -1; to = 1'b1;
        rise_n = -100; prev_done = gcd_done;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (gcd_done && !prev_done) rise_n = n;
            prev_done = gcd_done;
            if (resp_valid !== '0) begin
                idx = $onehot(resp_valid) ? $clog2(resp_valid) : -2;
                res = resp_result; err = resp_err; lat = n - rise_n; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_dataa = '0; req_datab = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({resp_valid, resp_result, resp_err, busy, gcd_start, gcd_dataa, gcd_datab} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rv=%b res=%0d err=%b busy=%b st=%b a=%0d b=%0d want all 0",
                     resp_valid, resp_result, resp_err, busy, gcd_start, gcd_dataa, gcd_datab);
        end
        rst = 1'b0; ref_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int idx, lat; logic [W-1:0] res; logic err; bit to;
        set_op(0, 32'd48, 32'd18);
        req_valid = 4'b0001;
        @(negedge clk);
        n_cmp++;
        if ({gcd_start, busy, gcd_dataa, gcd_datab} !== {1'b1, 1'b1, 32'd48, 32'd18}) begin
            n_fail++;
            $display("FAIL single_issue: got start=%b busy=%b a=%0d b=%0d want 1 1 48 18",
                     gcd_start, busy, gcd_dataa, gcd_datab);
        end
        req_dataa[W-1:0] = 32'd999;  // must be ignored after the grant
        wait_resp(50, idx, res, err, lat, to);
        n_cmp++;
        if ({to, idx, res, err} !== {1'b0, 32'sd0, 32'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL single_resp: got to=%b idx=%0d res=%0d err=%b want 0 0 6 0", to, idx, res, err);
        end
        n_cmp++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL single_latency: got %0d want 1", lat);
        end
        req_valid = '0; ref_ptr = 1;
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== '0) begin
            n_fail++; $display("FAIL single_pulse_width: got %b want 0000", resp_valid);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL single_idle_busy: got %b want 0", busy);
        end
    endtask

    // Runs n_tx transactions with the current held request set, re-requesting
    // each granted requester with new operands (or dropping it when drop_prob>0).
    task automatic run_held(input string name, input int n_tx, input int drop_prob,
                            input int add_prob);
        int idx, lat, exp; logic [W-1:0] res; logic err; bit to;
        for (int t = 0; t < n_tx; t++) begin
            if (req_valid == '0) begin
                req_valid = N'($urandom_range(1, (1 << N) - 1));
                for (int j = 0; j < N; j++) if (req_valid[j]) rand_op(j);
            end
            exp = ref_next(req_valid, ref_ptr);
            wait_resp(60, idx, res, err, lat, to);
            n_cmp++;
            if (to !== 1'b0 || idx !== exp || err !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_grant[%0d]: got to=%b idx=%0d err=%b want to=0 idx=%0d err=0",
                         name, t, to, idx, err, exp);
            end
            n_cmp++;
            if (exp >= 0 && res !== ref_gcd(opa[exp], opb[exp])) begin
                n_fail++;
                $display("FAIL %s_result[%0d]: got %0d want %0d", name, t, res, ref_gcd(opa[exp], opb[exp]));
            end
            n_cmp++;
            if (lat !== 1) begin
                n_fail++; $display("FAIL %s_latency[%0d]: got %0d want 1", name, t, lat);
            end
            if (exp >= 0) begin
                ref_ptr = (exp + 1) % N;
                if ($urandom_range(0, 99) < drop_prob) req_valid[exp] = 1'b0;
                else rand_op(exp);
            end
            for (int j = 0; j < N; j++) begin
                if (!req_valid[j] && $urandom_range(0, 99) < add_prob) begin
                    req_valid[j] = 1'b1; rand_op(j);
                end
            end
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rotation();
        for (int j = 0; j < N; j++) rand_op(j);
        req_valid = 4'b1111;
        run_held("rotation", 8, 0, 0);
    endtask

    task automatic test_alternate();
        rand_op(0); rand_op(2);
        req_valid = 4'b0101;
        run_held("alternate", 6, 0, 0);
    endtask

    task automatic test_zero_operands();
        int idx, lat; logic [W-1:0] res; logic err; bit to;
        logic [W-1:0] za [3];
        logic [W-1:0] zb [3];
        logic [W-1:0] zr [3];
        za[0] = 32'd0; zb[0] = 32'd7; zr[0] = 32'd7;
        za[1] = 32'd9; zb[1] = 32'd0; zr[1] = 32'd9;
        za[2] = 32'd0; zb[2] = 32'd0; zr[2] = 32'd0;
        for (int t = 0; t < 3; t++) begin
            set_op(1, za[t], zb[t]);
            req_valid = 4'b0010;
            wait_resp(60, idx, res, err, lat, to);
            n_cmp++;
            if (to !== 1'b0 || idx !== 1 || res !== zr[t]) begin
                n_fail++;
                $display("FAIL zero_op[%0d]: got to=%b idx=%0d res=%0d want 0 1 %0d", t, to, idx, res, zr[t]);
            end
            req_valid = '0;
            repeat (2) @(negedge clk);
        end
        ref_ptr = 2;
    endtask

    task automatic test_reset_mid_run();
        int idx, lat; logic [W-1:0] res; logic err; bit to; logic seen;
        rand_op(2);
        req_valid = 4'b0100; stuck = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({busy, gcd_start} !== 2'b10) begin
            n_fail++; $display("FAIL midrst_in_run: got busy=%b start=%b want 1 0", busy, gcd_start);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({resp_valid, resp_result, resp_err, busy, gcd_start, gcd_dataa, gcd_datab} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async_clear: got rv=%b res=%0d err=%b busy=%b st=%b a=%0d b=%0d want all 0",
                     resp_valid, resp_result, resp_err, busy, gcd_start, gcd_dataa, gcd_datab);
        end
        req_valid = '0; stuck = 1'b0;
        @(negedge clk);
        rst = 1'b0; ref_ptr = 0; seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | (|resp_valid);
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL midrst_no_resp: got resp_valid seen=%b want 0", seen);
        end
        rand_op(3);
        req_valid = 4'b1000;
        wait_resp(60, idx, res, err, lat, to);
        n_cmp++;
        if (to !== 1'b0 || idx !== 3 || res !== ref_gcd(opa[3], opb[3]) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_recover: got to=%b idx=%0d res=%0d err=%b want 0 3 %0d 0",
                     to, idx, res, err, ref_gcd(opa[3], opb[3]));
        end
        req_valid = '0; ref_ptr = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        run_held("random", 40, 50, 25);
    endtask

`ifdef GCD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n, idx, lat; logic [W-1:0] res; logic err; bit to; logic leak;
        stuck = 1'b1;
        set_op(0, 32'd100, 32'd75);
        req_valid = 4'b0001;
        @(negedge clk);
        n_cmp++;
        if (gcd_start !== 1'b1) begin
            n_fail++; $display("FAIL tmo_start: got %b want 1", gcd_start);
        end
        n = 0;
        while (resp_valid === '0 && n < 40) begin
            @(negedge clk); n++;
        end
        n_cmp++;
        if (n !== TMO || resp_valid !== 4'b0001 || resp_err !== 1'b1 || resp_result !== '0) begin
            n_fail++;
            $display("FAIL tmo_resp: got cycles=%0d rv=%b err=%b res=%0d want %0d 0001 1 0",
                     n, resp_valid, resp_err, resp_result, TMO);
        end
        ref_ptr = 1;
        leak = 1'b0;
        repeat (10) begin
            @(negedge clk);
            leak = leak | gcd_start | busy;
        end
        n_cmp++;
        if (leak !== 1'b0) begin
            n_fail++; $display("FAIL tmo_no_regrant: got start|busy seen=%b want 0", leak);
        end
        stuck = 1'b0;
        wait_resp(60, idx, res, err, lat, to);
        n_cmp++;
        if (to !== 1'b0 || idx !== 0 || res !== 32'd25 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_recover: got to=%b idx=%0d res=%0d err=%b want 0 0 25 0", to, idx, res, err);
        end
        req_valid = '0; ref_ptr = 1;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_alternate();
        test_zero_operands();
        test_reset_mid_run();
        test_random();
`ifdef GCD_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
